// File: rtl/ram_pkg.sv
// Shared types and default widths for the single-port RAM family.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every word from 0 to DEPTH-1 after reset or on request,
// holding busy while it runs. state_dbg exposes the FSM state.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic              state_dbg
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The terminal compare against DEPTH-1 stops the walk without relying on wrap.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    clr_we   = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt == LAST) state_nx = ST_IDLE;
        else             cnt_nx   = cnt + 1'b1;
      end
      ST_IDLE: begin
        if (clear) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  assign clr_addr  = cnt;
  assign state_dbg = state;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read, optional second output stage,
// read-valid strobe, error strobe and a hardware clear engine.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 1 << ADDR_W,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy,
  output logic              err
);

  // Handshake: wr/rd are single-cycle requests sampled on the clock edge with no
  // back-pressure; each accepted read yields exactly one out_valid pulse, each
  // refused request (busy or out of range) yields exactly one err pulse.

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              state_dbg;
  logic              idle, in_range, wr_ok, rd_ok, err_nx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .busy      (busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we),
    .state_dbg (state_dbg)
  );

  assign idle     = (state_dbg == ST_IDLE);
  assign in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
  assign wr_ok    = idle & wr & in_range;
  assign rd_ok    = idle & rd;
  assign err_nx   = (wr | rd) & ~(idle & in_range);

  // User writes are only accepted when idle, so the clear port never collides.
  assign mem_we    = clr_we | wr_ok;
  assign mem_addr  = clr_we ? clr_addr : address;
  assign mem_wdata = clr_we ? '0 : datain;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Read-first: the non-blocking write lands after this read samples the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      err      <= 1'b0;
    end else begin
      s1_valid <= rd_ok;
      err      <= err_nx;
      if (rd_ok) s1_data <= in_range ? mem[address] : '0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out       <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) out <= s1_data;
        end
      end
    end else begin : g_out_direct
      assign out       = s1_data;
      assign out_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: three instances (1024/latency1, 1024/latency2, 1000/latency1)
// share one directed stimulus stream and are checked against a per-instance model.
module tb_ram_sp_clr;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NI = 3;
  localparam int DEP [NI] = '{1024, 1024, 1000};
  localparam int LAT [NI] = '{1, 2, 1};

  logic          clk;
  logic          rst_n;
  logic          wr, rd, clear;
  logic [AW-1:0] address;
  logic [DW-1:0] datain;

  logic [DW-1:0] dout  [NI];
  logic          dval  [NI];
  logic          dbusy [NI];
  logic          derr  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .address(address), .datain(datain),
    .clear(clear), .out(dout[0]), .out_valid(dval[0]), .busy(dbusy[0]), .err(derr[0]));

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .address(address), .datain(datain),
    .clear(clear), .out(dout[1]), .out_valid(dval[1]), .busy(dbusy[1]), .err(derr[1]));

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1000), .OUT_REG(0)) u2 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .address(address), .datain(datain),
    .clear(clear), .out(dout[2]), .out_valid(dval[2]), .busy(dbusy[2]), .err(derr[2]));

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Clearing is modelled as an instantaneous wipe plus a busy countdown:
  // no request is accepted while busy, so intermediate contents are unobservable.
  logic [DW-1:0] mmem [NI][1024];
  int            busy_left [NI];
  logic [DW-1:0] e_out [NI];
  logic          e_val [NI];
  logic          e_err [NI];
  logic          d_v   [NI];
  logic [DW-1:0] d_d   [NI];

  task automatic wipe(input int i);
    for (int a = 0; a < 1024; a++) mmem[i][a] = '0;
  endtask

  task automatic model_step(input int i);
    bit            idle, legal, rv;
    logic [DW-1:0] rdat;
    if (!rst_n) begin
      busy_left[i] = DEP[i];
      e_out[i] = '0; e_val[i] = 1'b0; e_err[i] = 1'b0;
      d_v[i] = 1'b0; d_d[i] = '0;
      wipe(i);
    end else begin
      idle  = (busy_left[i] == 0);
      legal = (int'(address) < DEP[i]);
      e_err[i] = (wr || rd) && !(idle && legal);
      rv   = idle && rd;
      rdat = (rv && legal) ? mmem[i][address] : '0;
      if (idle && wr && legal) mmem[i][address] = datain;
      if (LAT[i] == 1) begin
        if (rv) e_out[i] = rdat;
        e_val[i] = rv;
      end else begin
        if (d_v[i]) e_out[i] = d_d[i];
        e_val[i] = d_v[i];
        d_v[i] = rv;
        d_d[i] = rdat;
      end
      if (idle && clear) begin
        wipe(i);
        busy_left[i] = DEP[i];
      end else if (busy_left[i] > 0) begin
        busy_left[i]--;
      end
    end
  endtask

  // ---------------- compare process + scoreboard ----------------
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) model_step(i);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("out", i, dout[i], e_out[i]);
      chk("out_valid", i, dval[i], e_val[i]);
      chk("err", i, derr[i], e_err[i]);
      chk("busy", i, dbusy[i], busy_left[i] > 0);
    end
    if (dval[0]) begin
      if (exp_q0.size() == 0) chk("sb_unexpected_read", 0, 1, 0);
      else chk("sb_read", 0, dout[0], exp_q0.pop_front());
    end
    if (dval[1]) begin
      if (exp_q1.size() == 0) chk("sb_unexpected_read", 1, 1, 0);
      else chk("sb_read", 1, dout[1], exp_q1.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic w, input logic r, input logic c,
                    input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr = w; rd = r; clear = c; address = a; datain = d;
    @(posedge clk);
    #3;
  endtask

  task automatic nop();
    op(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd_exp(input logic [AW-1:0] a, input logic [DW-1:0] v);
    exp_q0.push_back(v);
    exp_q1.push_back(v);
    op(1'b0, 1'b1, 1'b0, a, '0);
  endtask

  // Counts edges until busy falls on u0 and u2; a timeout leaves the count at 0.
  task automatic wait_clear(input int exp0, input int exp2);
    int n0 = 0;
    int n2 = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #3;
      if (!dbusy[0] && n0 == 0) n0 = c;
      if (!dbusy[2] && n2 == 0) n2 = c;
      if (n0 != 0 && n2 != 0) break;
    end
    chk("busy_cycles", 0, n0, exp0);
    chk("busy_cycles", 2, n2, exp2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clear = 1'b0; address = '0; datain = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 0, dbusy[0], 1);
    chk("reset_out", 0, dout[0], 0);
    chk("reset_valid", 1, dval[1], 0);
    chk("reset_err", 2, derr[2], 0);
    rst_n = 1'b1;
    wait_clear(1024, 1000);

    rd_exp(10'd0,    8'h00);
    rd_exp(10'd511,  8'h00);
    rd_exp(10'd1023, 8'h00);
    chk("oor_read_err", 2, derr[2], 1);

    op(1'b1, 1'b0, 1'b0, 10'd1, 8'h70);
    op(1'b1, 1'b0, 1'b0, 10'd3, 8'h2C);
    nop();
    rd_exp(10'd3, 8'h2C);
    chk("read3_out", 0, dout[0], 8'h2C);
    chk("read3_valid", 0, dval[0], 1);
    rd_exp(10'd4, 8'h00);
    rd_exp(10'd1, 8'h70);
    rd_exp(10'd3, 8'h2C);
    chk("lat2_out", 1, dout[1], 8'h70);

    exp_q0.push_back(8'h2C);
    exp_q1.push_back(8'h2C);
    op(1'b1, 1'b1, 1'b0, 10'd3, 8'h27);
    chk("read_first", 0, dout[0], 8'h2C);
    rd_exp(10'd3, 8'h27);
    nop();

    op(1'b1, 1'b0, 1'b0, 10'd1010, 8'h99);
    chk("oor_wr_err", 2, derr[2], 1);
    chk("inrange_wr_err", 0, derr[0], 0);
    rd_exp(10'd1010, 8'h99);
    chk("oor_rd_out", 2, dout[2], 0);
    chk("oor_rd_valid", 2, dval[2], 1);
    chk("oor_rd_err", 2, derr[2], 1);
    nop();

    // Clear, then a write (plus a repeated clear) while busy.
    op(1'b0, 1'b0, 1'b1, '0, '0);
    op(1'b1, 1'b0, 1'b1, 10'd2, 8'h55);
    chk("busy_wr_err", 0, derr[0], 1);
    chk("busy_wr_err", 1, derr[1], 1);
    wait_clear(1023, 999);
    rd_exp(10'd1, 8'h00);
    rd_exp(10'd2, 8'h00);
    nop();

    // Reset in the middle of a clear restarts it from zero.
    op(1'b0, 1'b0, 1'b1, '0, '0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midclear_reset_busy", 2, dbusy[2], 1);
    rst_n = 1'b1;
    wait_clear(1024, 1000);
    rd_exp(10'd3, 8'h00);
    repeat (4) nop();

    chk("sb_drain", 0, exp_q0.size(), 0);
    chk("sb_drain", 1, exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sp_clr.md
# ram_sp_clr

Parametrised single-port synchronous RAM, successor to the 8-bit × 1024 asynchronous-read RAM. It adds a clock, a registered read with an optional extra output stage, a read-valid strobe, and a hardware clear engine. The clear engine zeroes the array after reset and on request. It is the general storage primitive for buffers and lookup tables, and replaces the fixed 1024x8 RAM in new designs.

## Interface
- DATA_W, 8, data width in bits
- ADDR_W, 10, address width in bits
- DEPTH, 1<<ADDR_W, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W
- OUT_REG, 0, 1 adds a second output register stage (read latency 2 instead of 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr  in  1  write request, sampled at clk edge
- rd  in  1  read request, sampled at clk edge
- address  in  ADDR_W  word address for wr/rd
- datain  in  DATA_W  write data
- clear  in  1  request full-array clear (single-cycle pulse or level)
- out  out  DATA_W  read data, held between reads
- out_valid  out  1  one-cycle strobe; out carries new read data
- busy  out  1  clear engine active; requests are not accepted
- err  out  1  one-cycle strobe; request dropped (busy or address ≥ DEPTH)

## Operation
- FSM states: CLEAR, IDLE. Reset enters CLEAR with clear counter = 0.
- CLEAR:
  - Writes 0 to word [counter] every cycle and increments the counter.
  - After the write to DEPTH-1, moves to IDLE on the next edge.
  - busy=1 throughout.
- IDLE:
  - busy=0.
  - wr=1 with address < DEPTH writes datain to mem[address].
  - rd=1 with address < DEPTH returns mem[address] on out.
- Simultaneous wr and rd to the same address are read-first: out returns the old contents, and the new data is stored.
- clear=1 while in IDLE: moves to CLEAR next edge with counter=0. Any wr/rd in that same cycle is still serviced.
- clear=1 while in CLEAR is ignored; the clear does not restart.
- wr or rd while busy: no array or out effect, err=1 next cycle.
- Address ≥ DEPTH (only possible when DEPTH < 2^ADDR_W): write discarded; read returns 0 with out_valid=1; err=1.
- wr and rd both illegal in the same cycle: a single err pulse.
- The array itself has no reset. Contents are defined only via the clear engine.
- Reset asserted mid-clear or mid-read: all state returns to reset values, the clear restarts from 0, and the pending out_valid is discarded.

## Timing
- Reset values: out=0, out_valid=0, err=0, busy=1, state=CLEAR, counter=0.
- Clear duration:
  - busy is high for exactly DEPTH cycles after rst_n deasserts.
  - busy is high for exactly DEPTH cycles after the edge that samples clear.
- Write: takes effect at the sampling edge. A read on the following cycle returns the new data.
- Read latency:
  - OUT_REG=0: rd sampled at edge N → out/out_valid update at edge N+1.
  - OUT_REG=1: the update is at edge N+2.
  - out_valid stays aligned with out in both cases.
- Back-to-back reads give one result per cycle, fully pipelined.
- err: asserted on the edge after the offending request, same latency as out_valid for OUT_REG=0.
- Counter width: ADDR_W bits. Terminal compare is against DEPTH-1, so no wrap-around is used.

## Structure
- Shared package ram_pkg:
  - state typedef (CLEAR, IDLE)
  - default width constants DATA_W_DEF=8, ADDR_W_DEF=10
- Sub-module ram_clear_ctrl: FSM plus counter. It outputs busy, the clear address and the clear write enable.
- The top level contains:
  - the storage array
  - the write mux (clear vs user)
  - the read pipeline
  - err logic

## Test plan
- Reset release with DEPTH=1024: busy=1 for exactly 1024 cycles, then 0. Reading addresses 0, 511 and 1023 returns 0x00.
- Write 0x70@1, write 0x2C@3, idle cycle without a write to 4, read 3 → out=0x2C with out_valid one cycle later. Read 4 → 0x00.
- Same cycle wr=1, rd=1, address=3, datain=0x27 after 0x2C was stored → out=0x2C. The next read of 3 → 0x27.
- OUT_REG=1: reads of 1 then 3 back-to-back → 0x70, 0x2C on consecutive cycles, each 2 cycles after its rd.
- Pulse clear, then wr 0x55@2 while busy → err=1 and no write. After busy falls, reading address 1 returns 0x00 and reading address 2 returns 0x00.
- DEPTH=1000, ADDR_W=10: wr@1010 → err=1 and discarded; rd@1010 → out=0, out_valid=1, err=1. Assert rst_n=0 at clear count 500 → busy stays 1 and the clear restarts, completing 1000 cycles after release.
